// File: rtl/servo_pick_sequencer.sv
// ------------------------------------------------------------------------
// servo_pick_sequencer: pick/place/home pose sequencer with shared-frame servo PWM. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module servo_pick_sequencer #(
  parameter int CLK_PER_FRAME = 1000000,
  parameter int ARM_DOWN_W    = 118000,
  parameter int ARM_UP_W      = 135000,
  parameter int GRIP_OPEN_W   = 115000,
  parameter int GRIP_CLOSE_W  = 15000,
  parameter int GRIP_REST_W   = 65000,
  parameter int HOLD_FRAMES   = 10,
  parameter int WAIT_FRAMES   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       arm_pwm,
  output logic       grip_pwm,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] step
);

  localparam int CW   = $clog2(CLK_PER_FRAME);
  localparam int MAXF = (HOLD_FRAMES > WAIT_FRAMES) ? HOLD_FRAMES : WAIT_FRAMES;
  localparam int FW   = $clog2(MAXF + 1);

  localparam logic [CW-1:0] C_LAST       = CW'(CLK_PER_FRAME - 1);
  localparam logic [CW-1:0] C_ARM_DOWN   = CW'(ARM_DOWN_W);
  localparam logic [CW-1:0] C_ARM_UP     = CW'(ARM_UP_W);
  localparam logic [CW-1:0] C_GRIP_OPEN  = CW'(GRIP_OPEN_W);
  localparam logic [CW-1:0] C_GRIP_CLOSE = CW'(GRIP_CLOSE_W);
  localparam logic [CW-1:0] C_GRIP_REST  = CW'(GRIP_REST_W);
  localparam logic [FW-1:0] C_HOLD       = FW'(HOLD_FRAMES);
  localparam logic [FW-1:0] C_WAIT       = FW'(WAIT_FRAMES);

  localparam logic [1:0] OP_PICK = 2'b00;
  localparam logic [1:0] OP_HOME = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM_DOWN   = 3'd1,
    S_GRIP_OPEN  = 3'd2,
    S_DWELL      = 3'd3,
    S_GRIP_CLOSE = 3'd4,
    S_ARM_UP     = 3'd5,
    S_GRIP_REST  = 3'd6,
    S_PEND       = 3'd7
  } state_t;

  function automatic state_t first_step(input logic [1:0] op);
    first_step = (op == OP_HOME) ? S_ARM_UP : S_ARM_DOWN;
  endfunction

  // S_IDLE as a result means the sequence is complete.
  function automatic state_t next_step(input state_t s, input logic [1:0] op,
                                       input logic aborted);
    case (s)
      S_ARM_DOWN:   next_step = S_GRIP_OPEN;
      S_GRIP_OPEN:  next_step = S_DWELL;
      S_DWELL:      next_step = (op == OP_PICK) ? S_GRIP_CLOSE : S_ARM_UP;
      S_GRIP_CLOSE: next_step = S_ARM_UP;
      S_ARM_UP:     next_step = (op == OP_HOME && !aborted) ? S_GRIP_REST : S_IDLE;
      default:      next_step = S_IDLE;
    endcase
  endfunction

  state_t          state_q, state_d, nxt;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   arm_w_q, arm_w_d, grip_w_q, grip_w_d;
  logic [FW-1:0]   frames_q, frames_d, frames_inc, limit;
  logic [1:0]      op_q, op_d;
  logic            abort_q, abort_d;
  logic            arm_pwm_q, arm_pwm_d, grip_pwm_q, grip_pwm_d;
  logic            ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            frame_end, in_motion;

  assign frame_end  = (cnt_q == C_LAST);
  assign in_motion  = state_q inside {S_ARM_DOWN, S_GRIP_OPEN, S_DWELL, S_GRIP_CLOSE};
  assign frames_inc = frames_q + FW'(1);
  assign limit      = (state_q == S_DWELL) ? C_WAIT : C_HOLD;
  assign nxt        = next_step(state_q, op_q, abort_q);

  always_comb begin
    cnt_d    = frame_end ? '0 : cnt_q + CW'(1);
    state_d  = state_q;
    op_d     = op_q;
    frames_d = frames_q;
    abort_d  = abort_q | (abort & in_motion);
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          if (cmd_op == OP_RSVD) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            op_d     = cmd_op;
            abort_d  = 1'b0;
            frames_d = '0;
            // The first pose must start on a frame boundary strictly after acceptance.
            state_d  = frame_end ? first_step(cmd_op) : S_PEND;
          end
        end
      end
      S_PEND: begin
        if (frame_end) state_d = first_step(op_q);
      end
      default: begin
        if (frame_end) begin
          if (in_motion && (abort_q || abort)) begin
            state_d  = S_ARM_UP;
            frames_d = '0;
          end else if (frames_inc == limit) begin
            frames_d = '0;
            state_d  = nxt;
            if (nxt == S_IDLE) begin
              done_d = 1'b1;
              err_d  = abort_q;
            end
          end else begin
            frames_d = frames_inc;
          end
        end
      end
    endcase

    // Widths only reload at the frame start, so pulses are never cut short mid-frame.
    arm_w_d  = arm_w_q;
    grip_w_d = grip_w_q;
    if (cnt_q == '0) begin
      case (state_q)
        S_ARM_DOWN:   arm_w_d  = C_ARM_DOWN;
        S_ARM_UP:     arm_w_d  = C_ARM_UP;
        S_GRIP_OPEN:  grip_w_d = C_GRIP_OPEN;
        S_GRIP_CLOSE: grip_w_d = C_GRIP_CLOSE;
        S_GRIP_REST:  grip_w_d = C_GRIP_REST;
        default: ;
      endcase
    end

    arm_pwm_d  = (cnt_d < arm_w_d);
    grip_pwm_d = (cnt_d < grip_w_d);
    ready_d    = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      arm_w_q    <= C_ARM_UP;
      grip_w_q   <= C_GRIP_REST;
      frames_q   <= '0;
      op_q       <= OP_PICK;
      abort_q    <= 1'b0;
      arm_pwm_q  <= 1'b0;
      grip_pwm_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arm_w_q    <= arm_w_d;
      grip_w_q   <= grip_w_d;
      frames_q   <= frames_d;
      op_q       <= op_d;
      abort_q    <= abort_d;
      arm_pwm_q  <= arm_pwm_d;
      grip_pwm_q <= grip_pwm_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign arm_pwm   = arm_pwm_q;
  assign grip_pwm  = grip_pwm_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign step      = state_q;

endmodule

`default_nettype wire
